keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix keypad scanner for the RAT keypad peripheral (PmodKYPD).
//  - Drives the keypad columns and reads the rows.
//  - Debounces each press and turns it into a 4-bit key code.
//  - Presents the code to the RAT CPU input port with a valid/ack handshake and a 1-cycle interrupt pulse.
//  - Paces itself with an internal scan-tick counter (clock enable, no derived clock).
//    This block consumes the divided timebase.
// PARAMETERS
//  SCAN_DIV        100000  clk cycles per scan tick (1 ms @ 100 MHz); legal range >= 4
//  DEBOUNCE_SCANS  4       consecutive stable ticks required for press and for release; legal range >= 1
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst_n      in   1  asynchronous, active-low reset
//  row        in   4  keypad rows; active-low (pulled up); asynchronous to clk
//  col        out  4  keypad column drive; one-hot active-low
//  key_code   out  4  code of last accepted key; stable while key_valid=1
//  key_valid  out  1  new key available; held until acknowledged
//  key_ack    in   1  CPU acknowledge; 1-cycle strobe
//  intr       out  1  1-cycle pulse when a key is accepted (to RAT INT)
//  key_held   out  1  1 while accepted key not yet released
//  overrun    out  1  sticky: a press was accepted while key_valid=1
// BEHAVIOUR
//  Reset values (async, any time, aborts any state):
//    col=4'b1110, key_code=0, key_valid=0, intr=0, key_held=0, overrun=0;
//    state=SCAN, tick counter=0, debounce counter=0.
//  Row synchronizer:
//    row passes through a 2-FF synchronizer reset to 4'b1111; logic sees rs = ~row_sync.
//  Tick:
//    27-bit counter counts 0..SCAN_DIV-1; tick=1 for one cycle at SCAN_DIV-1, then wraps to 0.
//    All FSM decisions happen only on tick cycles.
//  State SCAN (on tick):
//    - rs==0: rotate col to the next column (1110->1101->1011->0111->1110).
//    - rs!=0: capture pattern=rs and col_idx; dcnt=1.
//      If DEBOUNCE_SCANS==1, accept immediately; otherwise go to DEBOUNCE. col is held.
//  State DEBOUNCE (on tick):
//    - rs==pattern: dcnt++; when dcnt==DEBOUNCE_SCANS, accept the key.
//    - otherwise: dcnt=0, rotate col, go to SCAN.
//  Accept:
//    - key_code = KEY_MAP[col_idx][lowest set bit of pattern]; multi-key in a column: lowest row wins.
//    - key_valid=1 and intr=1 for exactly 1 cycle; key_held=1; go to WAIT_RELEASE with dcnt=0.
//    - If key_valid was already 1 and no ack in the same cycle: overrun=1; key_code still updates.
//  State WAIT_RELEASE (on tick, col held):
//    - rs==0: dcnt++; else dcnt=0.
//    - When dcnt==DEBOUNCE_SCANS: key_held=0, rotate col, go to SCAN.
//  Handshake:
//    - key_ack with key_valid=1: key_valid=0 and overrun=0 on the next edge.
//    - key_ack with key_valid=0: ignored.
//    - Accept and ack in the same cycle: accept wins (key_valid stays 1, new code, no overrun).
//  Latency:
//    Stable press to intr <= 4*SCAN_DIV (column search) + DEBOUNCE_SCANS*SCAN_DIV + 3 cycles (sync + register).
//  KEY_MAP (col_idx 0..3 x row 0..3):
//    c0 = 1,4,7,0 | c1 = 2,5,8,F | c2 = 3,6,9,E | c3 = A,B,C,D.
// STRUCTURE
//  Package keypad_pkg holds:
//    - typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_RELEASE} kp_state_t
//    - const KEY_MAP[4][4]
//    - COL_RESET = 4'b1110
//  One sub-module: scan_tick_gen (parameter SCAN_DIV; ports clk, rst_n, tick).
//    Replaces the free-running divided-clock generator with a single-cycle enable.
//  FSM, synchronizer, handshake and code lookup live in keypad_scanner.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=2)
//  1. Reset: rst_n=0 mid-scan
//     -> col=1110, key_valid=0, intr=0, overrun=0 in the same cycle (async).
//  2. Hold row[1]=0 while col=1101 (key 5)
//     -> intr pulses once, key_code=4'h5, key_valid=1, key_held=1;
//     -> key_ack -> key_valid=0 next cycle.
//  3. Bounce: row[2] low for 1 tick, then high
//     -> no intr, col resumes rotating; a hold longer than 2 ticks -> key_code per column (e.g. col3 -> C).
//  4. Press 1, release, press 9 without ack
//     -> second intr, key_code=9, overrun=1;
//     -> key_ack clears key_valid and overrun.
//  5. Hold key 0 for 50 ticks
//     -> exactly one intr, col frozen at 1110;
//     -> release 2 ticks -> key_held=0, col advances to 1101.
//  6. Ack asserted in the same cycle as accept
//     -> key_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the PmodKYPD 4x4 keypad scanner.
// Holds the FSM state type, the key code map and the column and row decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_RELEASE} kp_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // KEY_MAP[col_idx][row]
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    function automatic logic [1:0] col_to_idx(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Several keys down in one column: the lowest row wins.
    function automatic logic [1:0] lowest_row(input logic [3:0] pat);
        logic [1:0] r;
        if (pat[0])      r = 2'd0;
        else if (pat[1]) r = 2'd1;
        else if (pat[2]) r = 2'd2;
        else if (pat[3]) r = 2'd3;
        else             r = 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-rate clock enable: a single-cycle tick every SCAN_DIV clocks.
// The tick asserts while the counter holds SCAN_DIV-1, and the counter then wraps to 0.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [26:0] r_cnt;

    assign tick = (r_cnt == 27'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_cnt <= '0;
        else if (tick) r_cnt <= '0;
        else           r_cnt <= r_cnt + 27'd1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives the columns, debounces the rows and decodes the key,
// then presents the key code to the CPU with a valid/ack handshake and an interrupt pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       intr,
    output logic       key_held,
    output logic       overrun
);

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    kp_state_t     r_state, w_state_n;
    logic [3:0]    r_col, w_col_n, w_col_rot;
    logic [3:0]    r_pat, w_pat_n;
    logic [1:0]    r_cidx, w_cidx_n;
    logic [DW-1:0] r_dcnt, w_dcnt_n, w_dcnt_inc;
    logic [3:0]    r_sync1, r_sync2, w_rs, w_code;
    logic          w_tick, w_accept, w_release;
    logic [3:0]    r_key_code;
    logic          r_valid, r_intr, r_held, r_ovr;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Rows are asynchronous and idle high; w_rs is the active-high pressed pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rs       = ~r_sync2;
    assign w_col_rot  = {r_col[2:0], r_col[3]};
    assign w_dcnt_inc = r_dcnt + DW'(1);
    assign w_code     = KEY_MAP[w_cidx_n][lowest_row(w_pat_n)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN;
            r_col   <= COL_RESET;
            r_pat   <= '0;
            r_cidx  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_col   <= w_col_n;
            r_pat   <= w_pat_n;
            r_cidx  <= w_cidx_n;
            r_dcnt  <= w_dcnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_col_n   = r_col;
        w_pat_n   = r_pat;
        w_cidx_n  = r_cidx;
        w_dcnt_n  = r_dcnt;
        w_accept  = 1'b0;
        w_release = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_rs == 4'b0000) begin
                        w_col_n = w_col_rot;
                    end else begin
                        w_pat_n  = w_rs;
                        w_cidx_n = col_to_idx(r_col);
                        w_dcnt_n = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            w_accept  = 1'b1;
                            w_dcnt_n  = '0;
                            w_state_n = WAIT_RELEASE;
                        end else begin
                            w_state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_rs == r_pat) begin
                        w_dcnt_n = w_dcnt_inc;
                        if (w_dcnt_inc == DW'(DEBOUNCE_SCANS)) begin
                            w_accept  = 1'b1;
                            w_dcnt_n  = '0;
                            w_state_n = WAIT_RELEASE;
                        end
                    end else begin
                        w_dcnt_n  = '0;
                        w_col_n   = w_col_rot;
                        w_state_n = SCAN;
                    end
                end
                WAIT_RELEASE: begin
                    if (w_rs == 4'b0000) begin
                        w_dcnt_n = w_dcnt_inc;
                        if (w_dcnt_inc == DW'(DEBOUNCE_SCANS)) begin
                            w_release = 1'b1;
                            w_dcnt_n  = '0;
                            w_col_n   = w_col_rot;
                            w_state_n = SCAN;
                        end
                    end else begin
                        w_dcnt_n = '0;
                    end
                end
                default: w_state_n = SCAN;
            endcase
        end
    end

    // A new accept always wins over an ack arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code <= '0;
            r_valid    <= 1'b0;
            r_intr     <= 1'b0;
            r_held     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_intr <= w_accept;
            if (w_accept) begin
                r_key_code <= w_code;
                r_valid    <= 1'b1;
                r_held     <= 1'b1;
                if (r_valid) r_ovr <= ~key_ack;
            end else if (key_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_release) r_held <= 1'b0;
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_valid;
    assign intr      = r_intr;
    assign key_held  = r_held;
    assign overrun   = r_ovr;

endmodule
